// File: rtl/ysyx_23060201_wbu.sv
// Writeback unit: accepts retired ops from EXU, waits on LSU for loads,
// extends load data, drives the GPR write port and the commit pulse.
module ysyx_23060201_wbu #(
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      exu_valid,
  output logic                      exu_ready,
  input  logic [GPR_ADDR_WIDTH-1:0] exu_rd,
  input  logic                      exu_rf_wen,
  input  logic                      exu_is_load,
  input  logic [2:0]                exu_ld_funct3,
  input  logic [1:0]                exu_addr_lo,
  input  logic [DATA_WIDTH-1:0]     exu_result,
  input  logic [31:0]               exu_pc,
  input  logic                      lsu_rvalid,
  input  logic [DATA_WIDTH-1:0]     lsu_rdata,
  output logic                      lsu_rready,
  output logic                      gpr_wen,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_waddr,
  output logic [DATA_WIDTH-1:0]     gpr_wdata,
  output logic                      commit_valid,
  output logic [31:0]               commit_pc,
  output logic                      wb_busy,
  output logic [GPR_ADDR_WIDTH-1:0] pend_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t                    r_state;
  logic [GPR_ADDR_WIDTH-1:0] r_rd;
  logic                      r_wen;
  logic                      r_load;
  logic [2:0]                r_f3;
  logic [1:0]                r_alo;
  logic [31:0]               r_pc;
  logic [DATA_WIDTH-1:0]     r_res;

  logic                      w_fire;
  logic                      w_in_wb;
  logic                      w_rd_nz;
  logic [7:0]                w_byte;
  logic [15:0]               w_half;
  logic [DATA_WIDTH-1:0]     w_ext;

  assign w_fire  = exu_valid & exu_ready;
  assign w_in_wb = (r_state == S_WB);
  assign w_rd_nz = |r_rd;

  // Select the addressed byte/half out of the raw memory word
  always_comb begin
    w_byte = lsu_rdata[{r_alo, 3'b000} +: 8];
    w_half = r_alo[1] ? lsu_rdata[31:16]
                      : lsu_rdata[15:0];
  end

  // Sign/zero-extend according to the latched load type
  always_comb begin
    w_ext = lsu_rdata;
    unique case (r_f3)
      3'b000:  w_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b100:  w_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_ext = lsu_rdata;
    endcase
  end

  // Stage FSM and held instruction fields; a fire can only
  // happen in IDLE or WB, so it overrides the per-state moves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rd    <= '0;
      r_wen   <= 1'b0;
      r_load  <= 1'b0;
      r_f3    <= '0;
      r_alo   <= '0;
      r_pc    <= '0;
      r_res   <= '0;
    end else if (w_fire) begin
      r_rd    <= exu_rd;
      r_wen   <= exu_rf_wen;
      r_load  <= exu_is_load;
      r_f3    <= exu_ld_funct3;
      r_alo   <= exu_addr_lo;
      r_pc    <= exu_pc;
      r_res   <= exu_result;
      r_state <= exu_is_load ? S_WAIT : S_WB;
    end else begin
      unique case (r_state)
        S_WAIT: begin
          if (lsu_rvalid) begin
            r_res   <= w_ext;
            r_state <= S_WB;
          end
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake and writeback outputs, all decoded from state/latches
  always_comb begin
    exu_ready    = (r_state != S_WAIT);
    lsu_rready   = (r_state == S_WAIT);
    wb_busy      = (r_state != S_IDLE);
    commit_valid = w_in_wb;
    gpr_wen      = w_in_wb & r_wen & w_rd_nz;
    gpr_waddr    = w_in_wb ? r_rd  : '0;
    gpr_wdata    = w_in_wb ? r_res : '0;
    commit_pc    = w_in_wb ? r_pc  : '0;
    pend_rd      = (wb_busy & r_wen & w_rd_nz) ? r_rd : '0;
  end

  logic w_unused;
  assign w_unused = r_load;

endmodule

// File: tb/tb_ysyx_23060201_wbu.sv
// Bench for ysyx_23060201_wbu: directed ops, a commit scoreboard
// checked every cycle, and literal checks that pin the model.
module tb_ysyx_23060201_wbu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exu_valid = 1'b0;
  logic        exu_ready;
  logic [4:0]  exu_rd = '0;
  logic        exu_rf_wen = 1'b0;
  logic        exu_is_load = 1'b0;
  logic [2:0]  exu_ld_funct3 = '0;
  logic [1:0]  exu_addr_lo = '0;
  logic [31:0] exu_result = '0;
  logic [31:0] exu_pc = '0;
  logic        lsu_rvalid = 1'b0;
  logic [31:0] lsu_rdata = '0;
  logic        lsu_rready;
  logic        gpr_wen;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        wb_busy;
  logic [4:0]  pend_rd;

  ysyx_23060201_wbu dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready),
    .exu_rd(exu_rd), .exu_rf_wen(exu_rf_wen),
    .exu_is_load(exu_is_load), .exu_ld_funct3(exu_ld_funct3),
    .exu_addr_lo(exu_addr_lo), .exu_result(exu_result),
    .exu_pc(exu_pc),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .lsu_rready(lsu_rready),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr),
    .gpr_wdata(gpr_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .wb_busy(wb_busy), .pend_rd(pend_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Architectural meaning of an RV32I load result
  function automatic logic [31:0] ext(input logic [2:0] f3,
                                      input logic [1:0] alo,
                                      input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * alo)) & 32'hFF;
    h = (w >> (16 * alo[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] pc,
                              input logic wen,
                              input logic [4:0] rd,
                              input logic [31:0] d);
    exp_t e;
    e.pc = pc;
    e.wen = wen && (rd != 0);
    e.addr = rd;
    e.data = d;
    return e;
  endfunction

  // Scoreboard: every retire must match the next expected commit,
  // and the write port must be quiet when nothing retires
  always @(negedge clk) begin
    if (rst_n) begin
      if (commit_valid) begin
        if (q.size() == 0) begin
          chk("commit_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_pc", commit_pc, e.pc);
          chk("sb_wen", {31'd0, gpr_wen}, {31'd0, e.wen});
          chk("sb_waddr", {27'd0, gpr_waddr}, {27'd0, e.addr});
          chk("sb_wdata", gpr_wdata, e.data);
        end
      end else begin
        chk("idle_wen", {31'd0, gpr_wen}, 32'd0);
        chk("idle_waddr", {27'd0, gpr_waddr}, 32'd0);
        chk("idle_wdata", gpr_wdata, 32'd0);
        chk("idle_pc", commit_pc, 32'd0);
      end
    end
  end

  // Present an op and hold it until it is accepted; returns just
  // after the accepting edge with exu_valid dropped
  task automatic issue(input logic [4:0] rd, input logic wen,
                       input logic ld, input logic [2:0] f3,
                       input logic [1:0] alo,
                       input logic [31:0] res,
                       input logic [31:0] pc);
    bit ok;
    ok = 0;
    exu_valid = 1'b1;
    exu_rd = rd;
    exu_rf_wen = wen;
    exu_is_load = ld;
    exu_ld_funct3 = f3;
    exu_addr_lo = alo;
    exu_result = res;
    exu_pc = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exu_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("issue_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    exu_valid = 1'b0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic wen,
                        input logic [31:0] res,
                        input logic [31:0] pc);
    q.push_back(mk(pc, wen, rd, res));
    issue(rd, wen, 1'b0, 3'd0, 2'd0, res, pc);
  endtask

  task automatic do_load(input logic [4:0] rd,
                         input logic [2:0] f3,
                         input logic [1:0] alo,
                         input logic [31:0] rdata,
                         input logic [31:0] pc,
                         input int waits,
                         input logic [31:0] lit);
    issue(rd, 1'b1, 1'b1, f3, alo, 32'h0BAD_0000, pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("ld_rready", {31'd0, lsu_rready}, 32'd1);
      chk("ld_pend", {27'd0, pend_rd}, {27'd0, rd});
      chk("ld_exu_ready", {31'd0, exu_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("model_pin", ext(f3, alo, rdata), lit);
    q.push_back(mk(pc, 1'b1, rd, ext(f3, alo, rdata)));
    lsu_rvalid = 1'b1;
    lsu_rdata = rdata;
    @(posedge clk);
    #1;
    lsu_rvalid = 1'b0;
    lsu_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    chk("ld_wdata", gpr_wdata, lit);
    chk("ld_commit", {31'd0, commit_valid}, 32'd1);
    chk("ld_wen", {31'd0, gpr_wen}, {31'd0, rd != 0});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, exu_ready}, 32'd1);
    chk("rst_rready", {31'd0, lsu_rready}, 32'd0);
    chk("rst_wen", {31'd0, gpr_wen}, 32'd0);
    chk("rst_commit", {31'd0, commit_valid}, 32'd0);
    chk("rst_waddr", {27'd0, gpr_waddr}, 32'd0);
    chk("rst_wdata", gpr_wdata, 32'd0);
    chk("rst_pc", commit_pc, 32'd0);
    chk("rst_busy", {31'd0, wb_busy}, 32'd0);
    chk("rst_pend", {27'd0, pend_rd}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU write, one-cycle latency, then back to idle
    alu_op(5'd5, 1'b1, 32'h1234_5678, 32'h8000_0000);
    @(negedge clk);
    chk("alu_wen", {31'd0, gpr_wen}, 32'd1);
    chk("alu_waddr", {27'd0, gpr_waddr}, 32'd5);
    chk("alu_wdata", gpr_wdata, 32'h1234_5678);
    chk("alu_commit", {31'd0, commit_valid}, 32'd1);
    chk("alu_pc", commit_pc, 32'h8000_0000);
    @(negedge clk);
    chk("alu_idle_busy", {31'd0, wb_busy}, 32'd0);
    chk("alu_idle_ready", {31'd0, exu_ready}, 32'd1);

    // Stray load data while idle must be ignored
    @(posedge clk);
    #1;
    lsu_rvalid = 1'b1;
    lsu_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    lsu_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rready", {31'd0, lsu_rready}, 32'd0);
    @(posedge clk);
    #1;

    // Load extension cases
    do_load(5'd3, 3'b000, 2'd2, 32'h0080_1122,
            32'h8000_0010, 3, 32'hFFFF_FF80);
    do_load(5'd6, 3'b101, 2'd2, 32'h8001_7FFF,
            32'h8000_0014, 1, 32'h0000_8001);
    do_load(5'd7, 3'b001, 2'd2, 32'h8001_7FFF,
            32'h8000_0018, 0, 32'hFFFF_8001);
    do_load(5'd8, 3'b001, 2'd0, 32'h8001_7FFF,
            32'h8000_001C, 2, 32'h0000_7FFF);
    do_load(5'd9, 3'b100, 2'd3, 32'h8001_7FFF,
            32'h8000_0020, 1, 32'h0000_0080);
    do_load(5'd10, 3'b000, 2'd1, 32'h8001_7FFF,
            32'h8000_0024, 0, 32'h0000_007F);
    do_load(5'd11, 3'b010, 2'd1, 32'h8001_7FFF,
            32'h8000_0028, 1, 32'h8001_7FFF);
    do_load(5'd12, 3'b110, 2'd0, 32'h8001_7FFF,
            32'h8000_002C, 0, 32'h8001_7FFF);
    do_load(5'd13, 3'b001, 2'd3, 32'h8001_7FFF,
            32'h8000_0030, 0, 32'hFFFF_8001);
    do_load(5'd0, 3'b010, 2'd0, 32'h1111_2222,
            32'h8000_0034, 1, 32'h1111_2222);

    // Write to x0 still commits but does not write
    alu_op(5'd0, 1'b1, 32'hDEAD_BEEF, 32'h8000_0040);
    @(negedge clk);
    chk("x0_commit", {31'd0, commit_valid}, 32'd1);
    chk("x0_wen", {31'd0, gpr_wen}, 32'd0);
    chk("x0_pend", {27'd0, pend_rd}, 32'd0);
    @(posedge clk);
    #1;

    // rf_wen=0 hides rd from hazard logic
    alu_op(5'd7, 1'b0, 32'h0000_0042, 32'h8000_0044);
    @(negedge clk);
    chk("nowen_pend", {27'd0, pend_rd}, 32'd0);
    chk("nowen_wen", {31'd0, gpr_wen}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back ALU ops: one commit per cycle
    exu_valid = 1'b1;
    exu_rf_wen = 1'b1;
    exu_is_load = 1'b0;
    exu_rd = 5'd1;
    exu_result = 32'h0000_0100;
    exu_pc = 32'h8000_0100;
    q.push_back(mk(exu_pc, 1'b1, exu_rd, exu_result));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        exu_rd = 5'(k + 1);
        exu_result = 32'h100 * (k + 1);
        exu_pc = 32'h8000_0100 + 32'(4 * k);
        q.push_back(mk(exu_pc, 1'b1, exu_rd, exu_result));
      end else begin
        exu_valid = 1'b0;
      end
      @(negedge clk);
      chk("b2b_commit", {31'd0, commit_valid}, 32'd1);
      chk("b2b_waddr", {27'd0, gpr_waddr}, 32'(k));
      chk("b2b_ready", {31'd0, exu_ready}, 32'd1);
    end
    @(negedge clk);
    chk("b2b_done", {31'd0, commit_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Reset during a pending load drops it
    issue(5'd9, 1'b1, 1'b1, 3'b010, 2'd0, 32'd0, 32'h8000_0200);
    @(negedge clk);
    chk("rm_pend", {27'd0, pend_rd}, 32'd9);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_busy", {31'd0, wb_busy}, 32'd0);
    chk("rm_ready", {31'd0, exu_ready}, 32'd1);
    chk("rm_rready", {31'd0, lsu_rready}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lsu_rvalid = 1'b1;
    lsu_rdata = 32'h7777_7777;
    @(posedge clk);
    #1;
    lsu_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rm_commit", {31'd0, commit_valid}, 32'd0);
      chk("rm_wen", {31'd0, gpr_wen}, 32'd0);
      chk("rm_idle", {31'd0, wb_busy}, 32'd0);
      chk("rm_ready2", {31'd0, exu_ready}, 32'd1);
    end

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_wbu.md
Name: ysyx_23060201_wbu

Overview:
Writeback unit sitting directly upstream of the general-purpose register file. It accepts completed instructions from the execute stage over a valid/ready handshake. For loads it waits on the LSU read-data channel, then aligns and sign/zero-extends the loaded value. It drives the register-file write port for one cycle, emits a commit pulse for difftest, and exposes the pending destination register for upstream hazard detection.

Parameters:
GPR_ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, datapath width; load-extension logic is defined for 32 only

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
exu_valid  in  1  execute stage presents an instruction
exu_ready  out  1  writeback can accept this cycle
exu_rd  in  GPR_ADDR_WIDTH  destination register
exu_rf_wen  in  1  instruction writes rd
exu_is_load  in  1  result comes from LSU
exu_ld_funct3  in  3  load type (RV32I funct3)
exu_addr_lo  in  2  load address bits [1:0]
exu_result  in  DATA_WIDTH  ALU/CSR/link result (ignored for loads)
exu_pc  in  32  instruction PC
lsu_rvalid  in  1  load data valid
lsu_rdata  in  DATA_WIDTH  raw aligned word from memory
lsu_rready  out  1  writeback accepts load data
gpr_wen  out  1  register-file write enable
gpr_waddr  out  GPR_ADDR_WIDTH  register-file write address
gpr_wdata  out  DATA_WIDTH  register-file write data
commit_valid  out  1  one-cycle retire pulse
commit_pc  out  32  PC of the retiring instruction
wb_busy  out  1  an instruction is held in this stage
pend_rd  out  GPR_ADDR_WIDTH  held rd if it will write a nonzero register, else 0

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: state=IDLE and all latched fields are 0. Outputs exu_ready=1, lsu_rready=0, gpr_wen=0, commit_valid=0, gpr_waddr/gpr_wdata/commit_pc=0, wb_busy=0, pend_rd=0.
- Reset asserted mid-operation discards the held instruction. No write and no commit occur.
- FSM has three states: IDLE, WAIT_LSU, WB.
- exu_ready = (state==IDLE) or (state==WB). It is combinational from state only.
- Handshake fires when exu_valid and exu_ready. On fire, latch rd, rf_wen, is_load, funct3, addr_lo, pc, and result.
  - is_load=1 → next state WAIT_LSU.
  - is_load=0 → next state WB.
- WAIT_LSU:
  - lsu_rready=1.
  - On lsu_rvalid, replace the latched result with the extended load data → WB.
  - Otherwise stay, with no timeout.
  - exu_ready=0 in this state.
- lsu_rvalid outside WAIT_LSU is ignored. lsu_rready is 0 in IDLE and WB.
- WB lasts exactly one cycle and drives the following, all combinational from the latched fields:
  - gpr_wen = rf_wen and (rd != 0)
  - gpr_waddr = rd
  - gpr_wdata = latched result
  - commit_valid = 1
  - commit_pc = latched pc
- Next state from WB: IDLE, unless a new handshake fires in the same cycle. In that case the new instruction is latched and goes to WAIT_LSU or WB as above. This gives back-to-back ALU throughput of 1 instruction/cycle after the first.
- gpr_waddr/gpr_wdata are 0 outside WB.
- Load latency: commit occurs the cycle after lsu_rvalid. ALU latency: commit occurs the cycle after the handshake.
- Load extension (byte select by addr_lo, half select by addr_lo[1]):
  - 000 LB: sign-extend byte[addr_lo]
  - 001 LH: sign-extend half[addr_lo[1]]
  - 010 LW: full word
  - 100 LBU: zero-extend byte[addr_lo]
  - 101 LHU: zero-extend half[addr_lo[1]]
  - Other codes: full word
  - addr_lo[0] is ignored for halfwords; misalignment is not trapped here.
- Write to x0: the instruction still commits (commit_valid=1), but gpr_wen=0.
- wb_busy = (state != IDLE).
- pend_rd = rd when wb_busy and rf_wen and rd != 0; otherwise 0.

Test Plan:
- ALU write: handshake with rd=5, rf_wen=1, result=0x1234_5678, pc=0x8000_0000 → next cycle gpr_wen=1, waddr=5, wdata=0x12345678, commit_valid=1, commit_pc=0x80000000. Then return to IDLE.
- LB sign: funct3=000, addr_lo=2, rd=3; lsu_rvalid asserted after 3 cycles with rdata=0x00_80_11_22 → lsu_rready high for 3 cycles; pend_rd=3 throughout. The cycle after rvalid: wdata=0xFFFF_FF80, gpr_wen=1.
- LHU/LH: rdata=0x8001_7FFF, addr_lo=2 → LHU writes 0x0000_8001; LH writes 0xFFFF_8001. With addr_lo=0, LH writes 0x0000_7FFF.
- x0 target: rd=0, rf_wen=1, result=0xDEAD_BEEF → commit_valid=1, gpr_wen=0, pend_rd=0.
- Back-to-back: exu_valid held high with 4 ALU ops (rd=1..4) → commits on 4 consecutive cycles. exu_ready stays 1, and there is no bubble after the first.
- Reset mid-load: assert rst_n=0 in WAIT_LSU; later lsu_rvalid=1 after release → no gpr_wen, no commit. State is IDLE, exu_ready=1, wb_busy=0.
